// File: rtl/gtwizard_0_tx_startup_sequencer.sv
// -----------------------------------------------------------------------------
// gtwizard_0_tx_startup_sequencer
//
// Brings up the QPLL and the GT transmitter after the common reset stage.
// On START it pulses QPLLRESET, waits for QPLL lock, then pulses GTTXRESET and
// asserts TXUSERRDY. It reports completion once TXRESETDONE is seen. Timeouts
// retry the whole sequence a bounded number of times before giving up. Loss of
// lock after completion restarts the sequence automatically.
//
// Ports
//   STABLE_CLOCK       in   free-running stable clock, all logic on rising edge
//   SOFT_RESET         in   asynchronous active-high reset of all state
//   START              in   synchronous start/restart request (level, INIT/DONE/FAILED)
//   QPLLLOCK           in   asynchronous QPLL lock, synchronised internally
//   TXRESETDONE        in   asynchronous GT TX reset done, synchronised internally
//   QPLLRESET          out  QPLL reset pulse
//   GTTXRESET          out  GT TX reset
//   TXUSERRDY          out  TX user clock ready
//   TX_FSM_RESET_DONE  out  sequence complete
//   FAIL               out  retries exhausted (sticky until START)
//   RETRY_COUNT        out  failed attempts in the current sequence
// -----------------------------------------------------------------------------
module gtwizard_0_tx_startup_sequencer #(
    parameter int STABLE_CLOCK_PERIOD = 8,
    parameter int RESET_PULSE_CYCLES  = 4,
    parameter int LOCK_WAIT_CYCLES    = 1024,
    parameter int DONE_WAIT_CYCLES    = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       STABLE_CLOCK,
    input  logic       SOFT_RESET,
    input  logic       START,
    input  logic       QPLLLOCK,
    input  logic       TXRESETDONE,
    output logic       QPLLRESET,
    output logic       GTTXRESET,
    output logic       TXUSERRDY,
    output logic       TX_FSM_RESET_DONE,
    output logic       FAIL,
    output logic [3:0] RETRY_COUNT
);

    // Reject parameter sets the counters cannot represent.
    if (STABLE_CLOCK_PERIOD < 1 || RESET_PULSE_CYCLES < 1 ||
        LOCK_WAIT_CYCLES < 2 || LOCK_WAIT_CYCLES >= 65536 ||
        DONE_WAIT_CYCLES < 2 || DONE_WAIT_CYCLES >= 65536 ||
        RESET_PULSE_CYCLES >= 65536 ||
        MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_params
        $error("gtwizard_0_tx_startup_sequencer: parameter out of range");
    end

    localparam logic [15:0] PULSE_LAST = 16'(RESET_PULSE_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST  = 16'(LOCK_WAIT_CYCLES - 1);
    localparam logic [15:0] DONE_LAST  = 16'(DONE_WAIT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_INIT             = 3'd0,
        ST_ASSERT_PLL_RESET = 3'd1,
        ST_WAIT_PLL_LOCK    = 3'd2,
        ST_ASSERT_GT_RESET  = 3'd3,
        ST_WAIT_RESET_DONE  = 3'd4,
        ST_DONE             = 3'd5,
        ST_FAILED           = 3'd6
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] cycle_cnt;
    logic [3:0]  retry_next;
    logic [3:0]  retry_inc;
    logic        timeout;

    logic lock_meta;
    logic lock_s;
    logic done_meta;
    logic done_s;

    // Two-flop synchronisers for the asynchronous status pins.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its source; blocking here would
    // collapse the two synchroniser stages into one.
    always_ff @(posedge STABLE_CLOCK or posedge SOFT_RESET) begin
        if (SOFT_RESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            lock_meta <= QPLLLOCK;
            lock_s    <= lock_meta;
            done_meta <= TXRESETDONE;
            done_s    <= done_meta;
        end
    end

    // Next-state and retry bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state = state;
        retry_next = RETRY_COUNT;
        timeout    = 1'b0;
        retry_inc  = (RETRY_COUNT >= RETRY_MAX) ? RETRY_MAX : RETRY_COUNT + 4'd1;

        case (state)
            ST_INIT: begin
                if (START) begin
                    next_state = ST_ASSERT_PLL_RESET;
                    retry_next = '0;
                end
            end
            ST_ASSERT_PLL_RESET: begin
                if (cycle_cnt == PULSE_LAST) next_state = ST_WAIT_PLL_LOCK;
            end
            ST_WAIT_PLL_LOCK: begin
                // Lock arriving on the last counted cycle still wins.
                if (lock_s)                      next_state = ST_ASSERT_GT_RESET;
                else if (cycle_cnt == LOCK_LAST) timeout    = 1'b1;
            end
            ST_ASSERT_GT_RESET: begin
                next_state = ST_WAIT_RESET_DONE;
            end
            ST_WAIT_RESET_DONE: begin
                // Losing lock invalidates any done indication, so it is checked first.
                if (!lock_s)                     timeout    = 1'b1;
                else if (done_s)                 next_state = ST_DONE;
                else if (cycle_cnt == DONE_LAST) timeout    = 1'b1;
            end
            ST_DONE: begin
                if (!lock_s || START) begin
                    next_state = ST_ASSERT_PLL_RESET;
                    retry_next = '0;
                end
            end
            ST_FAILED: begin
                if (START) begin
                    next_state = ST_ASSERT_PLL_RESET;
                    retry_next = '0;
                end
            end
            default: next_state = ST_INIT;
        endcase

        if (timeout) begin
            retry_next = retry_inc;
            next_state = (retry_inc == RETRY_MAX) ? ST_FAILED : ST_ASSERT_PLL_RESET;
        end
    end

    // State register and cycle counter. The counter restarts on every state
    // change and only runs in the timed states.
    always_ff @(posedge STABLE_CLOCK or posedge SOFT_RESET) begin
        if (SOFT_RESET) begin
            state     <= ST_INIT;
            cycle_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cycle_cnt <= '0;
            end else if (state == ST_ASSERT_PLL_RESET || state == ST_WAIT_PLL_LOCK ||
                         state == ST_WAIT_RESET_DONE) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end else begin
                cycle_cnt <= '0;
            end
        end
    end

    // Outputs are decoded from next_state so each registered output is valid
    // in the first cycle the FSM spends in the new state.
    always_ff @(posedge STABLE_CLOCK or posedge SOFT_RESET) begin
        if (SOFT_RESET) begin
            QPLLRESET         <= 1'b0;
            GTTXRESET         <= 1'b1;
            TXUSERRDY         <= 1'b0;
            TX_FSM_RESET_DONE <= 1'b0;
            FAIL              <= 1'b0;
            RETRY_COUNT       <= '0;
        end else begin
            QPLLRESET         <= (next_state == ST_ASSERT_PLL_RESET);
            GTTXRESET         <= !(next_state == ST_WAIT_RESET_DONE || next_state == ST_DONE);
            TXUSERRDY         <= (next_state == ST_WAIT_RESET_DONE || next_state == ST_DONE);
            TX_FSM_RESET_DONE <= (next_state == ST_DONE);
            FAIL              <= (next_state == ST_FAILED);
            RETRY_COUNT       <= retry_next;
        end
    end

endmodule

// File: tb/tb_gtwizard_0_tx_startup_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gtwizard_0_tx_startup_sequencer
//
// Directed bench for the TX startup sequencer with short timeouts
// (64-cycle waits, 4-cycle QPLL reset pulse, 3 retries). Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_gtwizard_0_tx_startup_sequencer;

    localparam int W_QR   = 0;
    localparam int W_GT   = 1;
    localparam int W_URDY = 2;
    localparam int W_DONE = 3;
    localparam int W_FAIL = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       qplllock;
    logic       txresetdone;
    logic       qpllreset;
    logic       gttxreset;
    logic       txuserrdy;
    logic       tx_done;
    logic       fail;
    logic [3:0] retry_count;

    int n_checks = 0;
    int n_fails  = 0;

    gtwizard_0_tx_startup_sequencer #(
        .STABLE_CLOCK_PERIOD (8),
        .RESET_PULSE_CYCLES  (4),
        .LOCK_WAIT_CYCLES    (64),
        .DONE_WAIT_CYCLES    (64),
        .MAX_RETRIES         (3)
    ) dut (
        .STABLE_CLOCK      (clk),
        .SOFT_RESET        (rst),
        .START             (start),
        .QPLLLOCK          (qplllock),
        .TXRESETDONE       (txresetdone),
        .QPLLRESET         (qpllreset),
        .GTTXRESET         (gttxreset),
        .TXUSERRDY         (txuserrdy),
        .TX_FSM_RESET_DONE (tx_done),
        .FAIL              (fail),
        .RETRY_COUNT       (retry_count)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            W_QR:    return qpllreset;
            W_GT:    return gttxreset;
            W_URDY:  return txuserrdy;
            W_DONE:  return tx_done;
            W_FAIL:  return fail;
            default: return 1'bx;
        endcase
    endfunction

    // Count cycles until output w reaches v; an expired bound yields a count
    // that cannot match the expected latency.
    task automatic wait_check(input string tag, input int w, input logic v, input int exp_n);
        int n;
        n = 0;
        while (sig(w) !== v && n < exp_n + 20) begin
            step(1);
            n++;
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int highs;

        rst         = 1'b1;
        start       = 1'b0;
        qplllock    = 1'b0;
        txresetdone = 1'b0;

        // ---------------- reset values
        step(3);
        check("rst_qpllreset", 32'(qpllreset), 32'd0);
        check("rst_gttxreset", 32'(gttxreset), 32'd1);
        check("rst_txuserrdy", 32'(txuserrdy), 32'd0);
        check("rst_done",      32'(tx_done),   32'd0);
        check("rst_fail",      32'(fail),      32'd0);
        check("rst_retry",     32'(retry_count), 32'd0);
        rst = 1'b0;
        step(3);
        check("init_idle_qpllreset", 32'(qpllreset), 32'd0);
        check("init_idle_gttxreset", 32'(gttxreset), 32'd1);

        // ---------------- nominal bring-up
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("nom_qpllreset_rise", 32'(qpllreset), 32'd1);
        check("nom_gttxreset_held", 32'(gttxreset), 32'd1);
        wait_check("nom_qpllreset_width", W_QR, 1'b0, 4);
        step(15);
        qplllock = 1'b1;                              // 20 cycles after START
        wait_check("nom_lock_to_gttxreset_fall", W_GT, 1'b0, 4);
        check("nom_txuserrdy", 32'(txuserrdy), 32'd1);
        check("nom_done_not_yet", 32'(tx_done), 32'd0);
        step(10);
        txresetdone = 1'b1;
        wait_check("nom_resetdone_to_done", W_DONE, 1'b1, 3);
        check("nom_retry", 32'(retry_count), 32'd0);
        check("nom_fail",  32'(fail),        32'd0);

        // ---------------- lock loss while done
        qplllock    = 1'b0;
        txresetdone = 1'b0;
        wait_check("loss_pin_to_done_fall", W_DONE, 1'b0, 3);
        check("loss_txuserrdy_fall", 32'(txuserrdy), 32'd0);
        check("loss_qpllreset_rise", 32'(qpllreset), 32'd1);
        step(2);
        qplllock = 1'b1;                              // lock absent for 5 cycles
        wait_check("loss_qpllreset_width_rest", W_QR, 1'b0, 2);
        wait_check("loss_relock_gttxreset", W_GT, 1'b0, 2);
        txresetdone = 1'b1;
        wait_check("loss_recomplete", W_DONE, 1'b1, 3);
        check("loss_retry", 32'(retry_count), 32'd0);

        // ---------------- done timeout then success
        start       = 1'b1;
        txresetdone = 1'b0;
        step(1);
        start = 1'b0;
        check("dto_restart_qpllreset", 32'(qpllreset), 32'd1);
        check("dto_restart_done_low",  32'(tx_done),   32'd0);
        wait_check("dto_gttxreset_fall", W_GT, 1'b0, 6);
        wait_check("dto_timeout", W_GT, 1'b1, 64);
        check("dto_retry_after_timeout", 32'(retry_count), 32'd1);
        check("dto_second_pulse", 32'(qpllreset), 32'd1);
        txresetdone = 1'b1;
        wait_check("dto_second_done", W_DONE, 1'b1, 7);
        check("dto_retry_final", 32'(retry_count), 32'd1);
        check("dto_fail", 32'(fail), 32'd0);

        // ---------------- lock timeout to FAILED
        qplllock    = 1'b0;
        txresetdone = 1'b0;
        wait_check("lto_first_pulse", W_QR, 1'b1, 3);
        check("lto_retry_cleared", 32'(retry_count), 32'd0);
        wait_check("lto_pulse1_width", W_QR, 1'b0, 4);
        wait_check("lto_pulse2_gap", W_QR, 1'b1, 64);
        check("lto_retry1", 32'(retry_count), 32'd1);
        wait_check("lto_pulse2_width", W_QR, 1'b0, 4);
        wait_check("lto_pulse3_gap", W_QR, 1'b1, 64);
        check("lto_retry2", 32'(retry_count), 32'd2);
        wait_check("lto_pulse3_width", W_QR, 1'b0, 4);
        wait_check("lto_fail_rise", W_FAIL, 1'b1, 64);
        check("lto_retry3", 32'(retry_count), 32'd3);
        check("lto_fail_gttxreset", 32'(gttxreset), 32'd1);
        check("lto_fail_txuserrdy", 32'(txuserrdy), 32'd0);
        check("lto_fail_qpllreset", 32'(qpllreset), 32'd0);
        step(10);
        check("lto_fail_sticky", 32'(fail),        32'd1);
        check("lto_retry_sat",   32'(retry_count), 32'd3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("lto_start_clears_fail",  32'(fail),        32'd0);
        check("lto_start_clears_retry", 32'(retry_count), 32'd0);
        check("lto_start_qpllreset",    32'(qpllreset),   32'd1);

        // ---------------- lock seen on the last counted cycle
        wait_check("bnd_qpllreset_width", W_QR, 1'b0, 4);
        step(30);
        start = 1'b1;                                 // ignored while waiting for lock
        step(1);
        start = 1'b0;
        check("bnd_start_ignored", 32'(qpllreset), 32'd0);
        step(30);
        qplllock = 1'b1;                              // lock_s lands with counter==63
        wait_check("bnd_lock_wins", W_GT, 1'b0, 4);
        check("bnd_retry", 32'(retry_count), 32'd0);
        check("bnd_fail",  32'(fail),        32'd0);
        txresetdone = 1'b1;
        wait_check("bnd_done", W_DONE, 1'b1, 3);

        // ---------------- async reset while QPLLRESET is high
        qplllock    = 1'b0;
        txresetdone = 1'b0;
        wait_check("ar1_done_fall", W_DONE, 1'b0, 3);
        check("ar1_qpllreset_high", 32'(qpllreset), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar1_qpllreset_async", 32'(qpllreset), 32'd0);
        check("ar1_gttxreset_async", 32'(gttxreset), 32'd1);
        check("ar1_txuserrdy_async", 32'(txuserrdy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(10);
        check("ar1_idle_qpllreset", 32'(qpllreset), 32'd0);

        // ---------------- async reset mid WAIT_PLL_LOCK after one retry
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_check("ar2_pulse1_width", W_QR, 1'b0, 4);
        wait_check("ar2_pulse2_gap", W_QR, 1'b1, 64);
        wait_check("ar2_pulse2_width", W_QR, 1'b0, 4);
        check("ar2_retry_before", 32'(retry_count), 32'd1);
        step(5);
        #3;
        rst = 1'b1;
        #1;
        check("ar2_retry_async",     32'(retry_count), 32'd0);
        check("ar2_gttxreset_async", 32'(gttxreset),   32'd1);
        check("ar2_fail_async",      32'(fail),        32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (qpllreset !== 1'b0) highs++;
        end
        check("ar2_no_pulse_without_start", 32'(highs), 32'd0);

        // ---------------- fresh START after reset completes normally
        qplllock    = 1'b1;
        txresetdone = 1'b1;
        start       = 1'b1;
        step(1);
        start = 1'b0;
        check("post_start_qpllreset", 32'(qpllreset), 32'd1);
        wait_check("post_done", W_DONE, 1'b1, 7);
        check("post_retry", 32'(retry_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
